// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared fetch-control definitions: widths, default PC constants, FSM encoding.
// Imported by the redirect controller, its interface and the bench.
package pc_redirect_ctrl_pkg;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0] DEFAULT_PC_INC   = 16'h0002;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // A resolved EX instruction changes the fetch stream when it is a taken branch or a jump.
    function automatic logic is_redirect(input logic br_ex, input logic br_taken, input logic jmp_ex);
        return (br_ex & br_taken) | jmp_ex;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Pipeline-facing bundle of the fetch redirect controller.
// slave is the controller side; master is the pipeline/hazard side.
interface pc_redirect_ctrl_if;
    import pc_redirect_ctrl_pkg::*;

    logic             stall;
    logic             br_ex;
    logic             br_taken;
    logic             jmp_ex;
    logic [PC_W-1:0]  target_ex;
    logic             halt_id;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, br_ex, br_taken, jmp_ex, target_ex, halt_id,
        input  pc, pc_plus, flush_if_id, flush_id_ex, halted, taken_cnt
    );

    modport slave (
        input  stall, br_ex, br_taken, jmp_ex, target_ex, halt_id,
        output pc, pc_plus, flush_if_id, flush_id_ex, halted, taken_cnt
    );

endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with branch/jump redirect, one-cycle IF flush shadow and HALT.
// Flush and halted are decoded from state plus the current EX/ID inputs.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] PC_INC   = DEFAULT_PC_INC
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_redirect_ctrl_if.slave bus
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pc_plus_c;
    logic [CNT_W-1:0] taken_cnt_q;
    logic             redirect_c;
    logic             cnt_inc_c;
    logic             flush_if_id_c;
    logic             flush_id_ex_c;
    logic             halted_c;

    assign pc_plus_c  = pc_q + PC_INC;
    assign redirect_c = is_redirect(bus.br_ex, bus.br_taken, bus.jmp_ex);

    // Next state, next PC and combinational decode; redirect outranks halt and stall.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_inc_c     = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        halted_c      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_c) begin
                    flush_if_id_c = rst_n;
                    flush_id_ex_c = rst_n;
                    cnt_inc_c     = 1'b1;
                    pc_d          = bus.target_ex;
                    state_d       = ST_FLUSH;
                end else if (bus.halt_id) begin
                    state_d = ST_HALT;
                end else if (!bus.stall) begin
                    pc_d = pc_plus_c;
                end
            end
            // The instructions in ID/EX here are already squashed, so their control bits are ignored.
            ST_FLUSH: begin
                flush_if_id_c = rst_n;
                pc_d          = pc_plus_c;
                state_d       = ST_RUN;
            end
            ST_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc_c),
        .count (taken_cnt_q)
    );

    assign bus.pc          = pc_q;
    assign bus.pc_plus     = pc_plus_c;
    assign bus.flush_if_id = flush_if_id_c;
    assign bus.flush_id_ex = flush_id_ex_c;
    assign bus.halted      = halted_c;
    assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: per-cycle expectations queued with the stimulus,
// popped and checked mid-cycle; plus a narrow sat_counter saturation check.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic        fif;
        logic        fie;
        logic        hlt;
        logic [15:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sat_inc;
    logic [3:0] sat_cnt;
    int         tests;
    int         fails;
    exp_t       q[$];

    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl #(
        .RESET_PC (16'h0000),
        .PC_INC   (16'h0002)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sat_counter #(
        .WIDTH (4)
    ) u_sat4 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sat_inc),
        .count (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = q.pop_front();
        chk("pc",          bus.pc,                 e.pc);
        chk("pc_plus",     bus.pc_plus,            e.pc + 16'h0002);
        chk("flush_if_id", 16'(bus.flush_if_id),   16'(e.fif));
        chk("flush_id_ex", 16'(bus.flush_id_ex),   16'(e.fie));
        chk("halted",      16'(bus.halted),        16'(e.hlt));
        chk("taken_cnt",   bus.taken_cnt,          e.cnt);
    endtask

    task automatic now_chk(input logic [15:0] e_pc, input logic e_fif, input logic e_fie,
                           input logic e_hlt, input logic [15:0] e_cnt);
        exp_t e;
        e = '{pc: e_pc, fif: e_fif, fie: e_fie, hlt: e_hlt, cnt: e_cnt};
        q.push_back(e);
        check_outputs();
    endtask

    // One fetch cycle: drive after the falling edge, check before the next rising edge.
    task automatic cyc(input logic st, input logic br, input logic tk, input logic jmp,
                       input logic [15:0] tgt, input logic hlt,
                       input logic [15:0] e_pc, input logic e_fif, input logic e_fie,
                       input logic e_hlt, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        bus.stall     = st;
        bus.br_ex     = br;
        bus.br_taken  = tk;
        bus.jmp_ex    = jmp;
        bus.target_ex = tgt;
        bus.halt_id   = hlt;
        e = '{pc: e_pc, fif: e_fif, fie: e_fie, hlt: e_hlt, cnt: e_cnt};
        q.push_back(e);
        #1;
        check_outputs();
    endtask

    task automatic clear_inputs();
        bus.stall     = 1'b0;
        bus.br_ex     = 1'b0;
        bus.br_taken  = 1'b0;
        bus.jmp_ex    = 1'b0;
        bus.target_ex = 16'h0000;
        bus.halt_id   = 1'b0;
    endtask

    // Release reset just after a rising edge so the next sample still sees RESET_PC.
    task automatic release_reset();
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        sat_inc = 1'b0;
        tests   = 0;
        fails   = 0;
        clear_inputs();
        bus.jmp_ex    = 1'b1;
        bus.target_ex = 16'hBEEF;
        #2;
        now_chk(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        release_reset();

        // Sequential fetch from reset
        cyc(0,0,0,0,16'h0000,0, 16'h0000,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h0002,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h0004,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h0006,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h0008,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h000A,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h000C,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h000E,0,0,0,16'h0000);

        // Taken branch, then squashed jump/halt during FLUSH
        cyc(0,1,1,0,16'h0040,0, 16'h0010,1,1,0,16'h0000);
        cyc(0,0,0,1,16'h1234,1, 16'h0040,1,0,0,16'h0001);
        // Not-taken branch under stall
        cyc(1,1,0,0,16'h0000,0, 16'h0042,0,0,0,16'h0001);
        // Jump beats halt and stall
        cyc(1,0,0,1,16'h0100,1, 16'h0042,1,1,0,16'h0001);
        cyc(0,0,0,0,16'h0000,0, 16'h0100,1,0,0,16'h0002);
        cyc(1,0,0,0,16'h0000,0, 16'h0102,0,0,0,16'h0002);
        cyc(0,0,0,1,16'h001E,0, 16'h0102,1,1,0,16'h0002);
        cyc(0,0,0,0,16'h0000,0, 16'h001E,1,0,0,16'h0003);

        // Halt with stall at 0020; HALT ignores jumps and branches
        cyc(1,0,0,0,16'h0000,1, 16'h0020,0,0,0,16'h0003);
        for (int i = 0; i < 10; i++) begin
            cyc(i[0], 1'b1, 1'b1, ~i[0], 16'h5555, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h0003);
        end

        // Reset out of HALT while a redirect is presented
        #1;
        rst_n = 1'b0;
        #1;
        now_chk(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        release_reset();

        // Jump to FFFE then wrap
        cyc(0,0,0,1,16'hFFFE,0, 16'h0000,1,1,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'hFFFE,1,0,0,16'h0001);
        cyc(0,0,0,0,16'h0000,0, 16'h0000,0,0,0,16'h0001);
        cyc(0,0,0,1,16'h0800,0, 16'h0002,1,1,0,16'h0001);
        cyc(0,0,0,0,16'h0000,0, 16'h0800,1,0,0,16'h0002);

        // Reset in the middle of FLUSH
        #1;
        rst_n = 1'b0;
        #1;
        now_chk(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        release_reset();
        cyc(0,0,0,0,16'h0000,0, 16'h0000,0,0,0,16'h0000);
        cyc(0,0,0,0,16'h0000,0, 16'h0002,0,0,0,16'h0000);

        // Saturation of a narrow counter instance
        @(negedge clk);
        sat_inc = 1'b1;
        repeat (14) @(negedge clk);
        chk("sat_cnt_14", 16'(sat_cnt), 16'h000E);
        repeat (6) @(negedge clk);
        chk("sat_cnt_sat", 16'(sat_cnt), 16'h000F);
        sat_inc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_INC, default 16'h0002, sequential fetch increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hazard-unit fetch stall; holds PC when no redirect.
REQ-006 br_ex  input  1  EX-stage instruction is a conditional branch.
REQ-007 br_taken  input  1  branch-decision output for the EX instruction; meaningful only with br_ex.
REQ-008 jmp_ex  input  1  EX-stage instruction is an unconditional jump.
REQ-009 target_ex  input  16  resolved branch/jump target address.
REQ-010 halt_id  input  1  ID-stage instruction is HALT.
REQ-011 pc  output  16  current fetch address.
REQ-012 pc_plus  output  16  pc + PC_INC, modulo 2^16.
REQ-013 flush_if_id  output  1  squash IF/ID contents this cycle.
REQ-014 flush_id_ex  output  1  squash ID/EX contents this cycle.
REQ-015 halted  output  1  fetch permanently stopped.
REQ-016 taken_cnt  output  16  count of redirects since reset.

Function
REQ-017 redirect SHALL be (br_ex AND br_taken) OR jmp_ex, combinational.
REQ-018 States SHALL be RUN, FLUSH, HALT.
REQ-019 In RUN with redirect: flush_if_id and flush_id_ex SHALL assert the same cycle; pc loads target_ex next edge; state goes to FLUSH.
REQ-020 FLUSH SHALL last exactly one cycle: flush_if_id asserted, flush_id_ex deasserted, pc advances normally; then return to RUN.
REQ-021 In FLUSH, br_ex, jmp_ex and halt_id SHALL be ignored, since the instructions carrying them are squashed.
REQ-022 In RUN without redirect: stall=1 holds pc; stall=0 loads pc_plus.
REQ-023 Redirect SHALL take priority over stall and halt_id in the same cycle.
REQ-024 In RUN, halt_id=1 with no redirect SHALL hold pc and enter HALT next edge, including when stall=1.
REQ-025 In HALT: pc frozen, halted=1, both flush outputs 0, all inputs ignored; exit only by reset.
REQ-026 taken_cnt SHALL increment by 1 on each edge where RUN and redirect hold, and SHALL saturate at 16'hFFFF.
REQ-027 pc and pc_plus arithmetic SHALL wrap at 16 bits; target_ex SHALL be loaded unmodified.
REQ-028 pc SHALL be registered; flush outputs and halted SHALL be decoded from state and current inputs with no added latency.

Reset
REQ-029 rst_n low SHALL asynchronously force pc=RESET_PC, state=RUN, taken_cnt=0, halted=0.
REQ-030 During reset, flush_if_id and flush_id_ex SHALL read 0.
REQ-031 Reset asserted mid-FLUSH or mid-HALT SHALL override that state immediately.
REQ-032 The first edge after rst_n rises SHALL behave as RUN.

Structure
REQ-033 The state encoding (RUN, FLUSH, HALT) and the default RESET_PC/PC_INC constants SHALL live in the shared processor package.
REQ-034 The saturating taken_cnt SHALL be a sub-module named sat_counter, parameterised by width.

Verification
REQ-035 Reset release, no stall, 4 cycles -> pc sequence 0000, 0002, 0004, 0006; taken_cnt=0.
REQ-036 pc=0010, br_ex=1, br_taken=1, target_ex=0040 -> both flushes high that cycle; next pc=0040 with flush_if_id only; then pc=0042 and taken_cnt=1.
REQ-037 br_ex=1, br_taken=0, stall=1 -> no flush, pc held, taken_cnt unchanged.
REQ-038 jmp_ex=1, halt_id=1 and stall=1 in the same cycle -> redirect wins, pc=target_ex, halted stays 0.
REQ-039 halt_id=1 at pc=0020 -> halted=1 next cycle; pc stays 0020 for 10 cycles despite jmp_ex pulses; rst_n pulse -> pc=0000, halted=0.
REQ-040 pc=FFFE with no stall -> next pc=0000; 65536 redirects -> taken_cnt holds at FFFF.
